// File: rtl/ccff_chain_loader.sv
// ccff_chain_loader
//   Loads a configuration chain of dffre cells. The cells are wired as a Q->D
//   daisy chain with a shared E and C. Bitstream words arrive on a valid/ready
//   stream. Each word is serialised LSB-first onto ccff_head. ccff_en is gated
//   so that exactly CHAIN_LEN bits are shifted per load.
//
//   Optional feature macro: CCFF_VERIFY_EN
//     When defined, a VERIFY pass follows the last shift. It recirculates the
//     chain for CHAIN_LEN cycles (head = tail), so the chain contents end up
//     unchanged. It counts the ones seen on ccff_tail and compares that count
//     with the ones shifted in. A mismatch sets err in DONE.
//     When undefined, there is no VERIFY state and err is tied low.
//
// Ports
//   C          clock, shared with the chain cells
//   R_N        asynchronous active-low reset
//   start      pulse: begin a load (honoured only in IDLE or DONE)
//   abort      return to IDLE on the next edge (priority over everything)
//   in_data    bitstream word, bit 0 shifted first
//   in_valid   in_data valid
//   in_ready   word accepted on in_valid && in_ready (high only in LOAD)
//   ccff_head  serial data to the first chain cell D
//   ccff_en    chain shift enable (dffre E)
//   ccff_tail  Q of the last chain cell
//   busy       high in LOAD / SHIFT / VERIFY
//   done       high in DONE until the next start or abort
//   err        verify mismatch, sticky until the next start

module ccff_chain_loader #(
    parameter int CHAIN_LEN = 128,
    parameter int WORD_W    = 8,
    parameter int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
    input  logic              C,
    input  logic              R_N,
    input  logic              start,
    input  logic              abort,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              ccff_head,
    output logic              ccff_en,
    input  logic              ccff_tail,
    output logic              busy,
    output logic              done,
    output logic              err
);

`ifdef CCFF_VERIFY_EN
    typedef enum logic [2:0] {IDLE, LOAD, SHIFT, VERIFY, DONE} state_t;
`else
    typedef enum logic [1:0] {IDLE, LOAD, SHIFT, DONE} state_t;
`endif

    state_t            state;
    logic [WORD_W-1:0] shreg;
    logic [WORD_W-1:0] shreg_nxt;
    logic [CNT_W-1:0]  bit_cnt;
    logic [CNT_W-1:0]  wcnt;
    logic [CNT_W-1:0]  remaining;
    logic [CNT_W-1:0]  word_bits;
    logic              head_q;
    logic              en_q;
    logic              busy_q;
    logic              done_q;

`ifdef CCFF_VERIFY_EN
    logic [CNT_W-1:0]  ones_cnt;
    logic [CNT_W-1:0]  tail_ones;
    logic [CNT_W-1:0]  vcnt;
    logic              err_q;
`endif

    // The final word is clamped to the bits still missing from the chain.
    // Its surplus high bits are never shifted.
    always_comb begin
        remaining = CNT_W'(CHAIN_LEN) - bit_cnt;
        if (32'(remaining) > WORD_W)
            word_bits = CNT_W'(WORD_W);
        else
            word_bits = remaining;
        shreg_nxt = shreg >> 1;
    end

    always_ff @(posedge C or negedge R_N) begin
        if (!R_N) begin
            state   <= IDLE;
            shreg   <= '0;
            bit_cnt <= '0;
            wcnt    <= '0;
            head_q  <= 1'b0;
            en_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef CCFF_VERIFY_EN
            ones_cnt  <= '0;
            tail_ones <= '0;
            vcnt      <= '0;
            err_q     <= 1'b0;
`endif
        end else if (abort) begin
            state  <= IDLE;
            head_q <= 1'b0;
            en_q   <= 1'b0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state   <= LOAD;
                        bit_cnt <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
`ifdef CCFF_VERIFY_EN
                        ones_cnt <= '0;
                        err_q    <= 1'b0;
`endif
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        // The head and enable are registered here, so the
                        // first bit reaches the chain on the next edge.
                        shreg  <= in_data;
                        wcnt   <= word_bits;
                        head_q <= in_data[0];
                        en_q   <= 1'b1;
                        state  <= SHIFT;
                    end
                end
                SHIFT: begin
                    shreg   <= shreg_nxt;
                    head_q  <= shreg_nxt[0];
                    bit_cnt <= bit_cnt + 1'b1;
                    wcnt    <= wcnt - 1'b1;
`ifdef CCFF_VERIFY_EN
                    ones_cnt <= ones_cnt + CNT_W'(head_q);
`endif
                    if (wcnt == CNT_W'(1)) begin
                        head_q <= 1'b0;
                        if (bit_cnt == CNT_W'(CHAIN_LEN - 1)) begin
`ifdef CCFF_VERIFY_EN
                            state     <= VERIFY;
                            vcnt      <= CNT_W'(CHAIN_LEN);
                            tail_ones <= '0;
`else
                            state  <= DONE;
                            en_q   <= 1'b0;
                            busy_q <= 1'b0;
                            done_q <= 1'b1;
`endif
                        end else begin
                            state <= LOAD;
                            en_q  <= 1'b0;
                        end
                    end
                end
`ifdef CCFF_VERIFY_EN
                VERIFY: begin
                    tail_ones <= tail_ones + CNT_W'(ccff_tail);
                    vcnt      <= vcnt - 1'b1;
                    if (vcnt == CNT_W'(1)) begin
                        err_q  <= (tail_ones + CNT_W'(ccff_tail)) != ones_cnt;
                        state  <= DONE;
                        en_q   <= 1'b0;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end
                end
`endif
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready = (state == LOAD);
    assign ccff_en  = en_q;
    assign busy     = busy_q;
    assign done     = done_q;

`ifdef CCFF_VERIFY_EN
    // Recirculate during verify: the tail feeds straight back into the head.
    assign ccff_head = (state == VERIFY) ? ccff_tail : head_q;
    assign err       = err_q;
`else
    logic unused_tail;
    assign unused_tail = ccff_tail;
    assign ccff_head   = head_q;
    assign err         = 1'b0;
`endif

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Testbench for ccff_chain_loader with CHAIN_LEN=10 and WORD_W=8.
// Each load uses two words, and only 2 bits of the second word are shifted.

module tb_ccff_chain_loader;
    localparam int N = 10;
    localparam int W = 8;
`ifdef CCFF_VERIFY_EN
    localparam int VER_CYC = N;
`else
    localparam int VER_CYC = 0;
`endif

    logic         C = 1'b0;
    logic         R_N = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] in_data = '0;
    logic         in_valid = 1'b0;
    logic         in_ready, ccff_head, ccff_en, ccff_tail, busy, done, err;

    logic [N-1:0] chain = '0;
    bit           stuck_en = 1'b0;
    int           stuck_idx = 0;
    int           en_total = 0;
    int           n_cmp = 0;
    int           n_bad = 0;

    always #5 C = ~C;

    ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) dut (
        .C(C), .R_N(R_N), .start(start), .abort(abort),
        .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
        .ccff_head(ccff_head), .ccff_en(ccff_en), .ccff_tail(ccff_tail),
        .busy(busy), .done(done), .err(err)
    );

    // Chain of dffre cells. Cell 0 takes ccff_head. Cell N-1 drives ccff_tail.
    // A cell can be made stuck-at-0.
    assign ccff_tail = chain[N-1];
    always @(posedge C) begin
        logic [N-1:0] nx;
        nx = {chain[N-2:0], ccff_head};
        if (stuck_en) nx[stuck_idx] = 1'b0;
        if (ccff_en) begin
            chain    <= nx;
            en_total <= en_total + 1;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference: the bit stream is the words LSB-first, word 0 first.
    // The first N bits enter the chain. Cell k ends up holding stream bit N-1-k.
    function automatic logic [N-1:0] ref_chain(input logic [W-1:0] w0, input logic [W-1:0] w1);
        logic [2*W-1:0] stream;
        logic [N-1:0]   r;
        stream = {w1, w0};
        r = '0;
        for (int i = 0; i < N; i++) r[N-1-i] = stream[i];
        return r;
    endfunction

    task automatic tick(inout int cyc);
        @(posedge C); #1;
        cyc++;
    endtask

    // Runs one complete load.
    //   s0, s1    : cycles in_valid is held low in LOAD before each word.
    //   start_mid : pulse start while the first word is shifting.
    task automatic do_load(input logic [W-1:0] w0, input logic [W-1:0] w1,
                           input int s0, input int s1, input bit start_mid,
                           output int cyc, output int en_cnt, output int stall_bad);
        logic [W-1:0] wq[2];
        int           st[2];
        int           en0;
        int           guard;
        logic [N-1:0] snap;
        wq[0] = w0; wq[1] = w1; st[0] = s0; st[1] = s1;
        cyc = 0; stall_bad = 0;
        @(negedge C); start = 1'b1; en0 = en_total;
        @(posedge C); #1; start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            guard = 0;
            while (!in_ready && guard < 100) begin tick(cyc); guard++; end
            check("in_ready_wait", 32'(in_ready), 32'd1);
            snap = chain;
            for (int s = 0; s < st[i]; s++) begin
                if (ccff_en !== 1'b0) stall_bad++;
                tick(cyc);
            end
            if (chain !== snap) stall_bad++;
            in_valid = 1'b1; in_data = wq[i];
            tick(cyc);
            in_valid = 1'b0; in_data = W'($urandom);
            if (i == 0 && start_mid) begin
                start = 1'b1; tick(cyc); start = 1'b0;
            end
        end
        guard = 0;
        while (!done && guard < 200) begin tick(cyc); guard++; end
        en_cnt = en_total - en0;
    endtask

    task automatic load_and_check(input string tag, input logic [W-1:0] w0, input logic [W-1:0] w1,
                                  input logic [N-1:0] exp_chain, input int s0, input int s1,
                                  input bit start_mid, input logic exp_err);
        int cyc, en_cnt, stall_bad;
        do_load(w0, w1, s0, s1, start_mid, cyc, en_cnt, stall_bad);
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy"}, 32'(busy), 32'd0);
        check({tag, "_chain"}, 32'(chain), 32'(exp_chain));
        check({tag, "_en_cycles"}, 32'(en_cnt), 32'(N + VER_CYC));
        check({tag, "_latency"}, 32'(cyc), 32'(2 + s0 + s1 + N + VER_CYC));
        check({tag, "_stall"}, 32'(stall_bad), 32'd0);
        check({tag, "_err"}, 32'(err), 32'(exp_err));
    endtask

    typedef struct {
        logic [W-1:0] w0;
        logic [W-1:0] w1;
        logic [N-1:0] exp_chain;
    } vec_t;

    initial begin
        vec_t vecs[6];
        int   cyc;
        logic [W-1:0] a, b;

        vecs[0] = '{8'hA5, 8'h3C, 10'h294};
        vecs[1] = '{8'hFF, 8'h03, 10'h3FF};
        vecs[2] = '{8'h00, 8'hFC, 10'h000};
        vecs[3] = '{8'hFF, 8'hFC, 10'h3FC};
        vecs[4] = '{8'h01, 8'h02, 10'h201};
        vecs[5] = '{8'h80, 8'hFD, 10'h006};

        #1 R_N = 1'b0;
        #2;
        check("reset_outputs", 32'({in_ready, ccff_en, ccff_head, busy, done, err}), 32'd0);
        repeat (2) @(posedge C);
        @(negedge C) R_N = 1'b1;
        @(posedge C); #1;
        check("idle_outputs", 32'({in_ready, ccff_en, busy, done, err}), 32'd0);

        for (int i = 0; i < 6; i++)
            load_and_check("vec", vecs[i].w0, vecs[i].w1, vecs[i].exp_chain, 0, 0, 1'b0, 1'b0);

        // done holds in DONE
        cyc = 0;
        repeat (3) tick(cyc);
        check("done_hold", 32'({done, busy, in_ready, ccff_en}), 32'b1000);

        // 20-cycle stall mid-load; start while busy is ignored
        load_and_check("stall", 8'h5A, 8'hFE, ref_chain(8'h5A, 8'hFE), 0, 20, 1'b0, 1'b0);
        load_and_check("start_busy", 8'hC3, 8'h01, ref_chain(8'hC3, 8'h01), 1, 0, 1'b1, 1'b0);

        // abort at bit 5 of the first word
        @(negedge C); start = 1'b1;
        @(posedge C); #1; start = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF;
        tick(cyc); in_valid = 1'b0;
        repeat (5) tick(cyc);
        check("abort_mid_en", 32'(ccff_en), 32'd1);
        abort = 1'b1; tick(cyc); abort = 1'b0;
        check("abort_outputs", 32'({in_ready, ccff_en, busy, done}), 32'd0);
        load_and_check("after_abort", vecs[0].w0, vecs[0].w1, vecs[0].exp_chain, 0, 0, 1'b0, 1'b0);

        // start together with abort from DONE: abort wins
        @(negedge C); start = 1'b1; abort = 1'b1;
        @(posedge C); #1; start = 1'b0; abort = 1'b0;
        check("start_abort", 32'({in_ready, busy, done}), 32'd0);

        // asynchronous reset between edges mid-shift
        @(negedge C); start = 1'b1;
        @(posedge C); #1; start = 1'b0;
        in_valid = 1'b1; in_data = 8'hFF;
        tick(cyc); in_valid = 1'b0;
        repeat (3) tick(cyc);
        #2 R_N = 1'b0;
        #1;
        check("async_reset", 32'({in_ready, ccff_en, ccff_head, busy, done, err}), 32'd0);
        @(negedge C) R_N = 1'b1;
        load_and_check("after_reset", vecs[1].w0, vecs[1].w1, vecs[1].exp_chain, 0, 0, 1'b0, 1'b0);

        // randomized loads against the stream reference
        for (int r = 0; r < 20; r++) begin
            a = W'($urandom);
            b = W'($urandom);
            load_and_check("rand", a, b, ref_chain(a, b),
                           int'($urandom_range(0, 3)), int'($urandom_range(0, 3)), 1'b0, 1'b0);
        end

`ifdef CCFF_VERIFY_EN
        // A stuck-at-0 cell that should hold a 1 must be flagged.
        stuck_idx = 3; stuck_en = 1'b1;
        begin
            int c2, e2, sb;
            do_load(8'hFF, 8'h03, 0, 0, 1'b0, c2, e2, sb);
            check("verify_stuck_done", 32'(done), 32'd1);
            check("verify_stuck_err", 32'(err), 32'd1);
        end
        stuck_en = 1'b0;
        load_and_check("verify_clean", 8'h96, 8'h02, ref_chain(8'h96, 8'h02), 0, 0, 1'b0, 1'b0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
